k_counter: RTL

K_COUNTER -- requirements
Module: k_counter

---
 rtl/k_counter_pkg.sv | 15 +
 rtl/mod_k_cnt.sv | 30 +++
 rtl/k_counter.sv | 87 ++++++++
 3 files changed

// File: rtl/k_counter_pkg.sv
// k_counter_pkg: shared constants and modulus helper for the k_counter digital PLL loop filter.
package k_counter_pkg;

   localparam int CNT_W_DEF  = 10;
   localparam int LOCK_W_DEF = 8;
   localparam int KM_W       = 3;

   // Modulus K = 2^min(kmode+3, cw); kmode values past the counter width saturate at 2^cw.
   function automatic int unsigned k_mod(input logic [KM_W-1:0] km, input int cw);
      int e;
      e = int'(km) + 3;
      return 32'd1 << ((e > cw) ? cw : e);
   endfunction

endpackage

// File: rtl/mod_k_cnt.sv
// mod_k_cnt: W-bit wrap counter with count enable, synchronous clear and registered terminal pulse.
module mod_k_cnt #(
   parameter int W = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_max,
   output logic         o_term,
   output logic         o_pulse
);

   logic [W-1:0] r_cnt;

   // A counted sample at the terminal value is the K-th event of the current cycle.
   assign o_term = i_en & (r_cnt == i_max);

   // Count, wrap at the terminal value and register the pulse one cycle later; clear wins over counting.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         o_pulse <= 1'b0;
      end else begin
         o_pulse <= o_term & ~i_clr;
         r_cnt   <= (i_clr | o_term) ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
      end
   end

endmodule

// File: rtl/k_counter.sv
// k_counter: 74297-style K counter (carry/borrow pulse generator with lock detect).
// Optional macro K_COUNTER_CROSS_CLEAR_EN: a carry also clears the down counter and a borrow the up counter.
module k_counter
   import k_counter_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int LOCK_W = LOCK_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            dnup,
   input  logic [KM_W-1:0] kmode,
   output logic            carry,
   output logic            borrow,
   output logic            lock
);

   logic [KM_W-1:0]   r_kmode;
   logic [LOCK_W-1:0] r_ltmr;
   logic [LOCK_W-1:0] w_ltmr_nxt;
   logic [CNT_W-1:0]  w_max;
   logic              w_kchg;
   logic              w_up_en;
   logic              w_dn_en;
   logic              w_up_clr;
   logic              w_dn_clr;
   logic              w_up_term;
   logic              w_dn_term;
   logic              w_pulse;

   // A kmode change suppresses counting for that cycle so no pulse can come out of a stale modulus.
   assign w_kchg  = kmode != r_kmode;
   assign w_max   = CNT_W'(k_mod(r_kmode, CNT_W) - 1);
   assign w_up_en = enable & ~dnup & ~w_kchg;
   assign w_dn_en = enable &  dnup & ~w_kchg;
   assign w_pulse = w_up_term | w_dn_term;

`ifdef K_COUNTER_CROSS_CLEAR_EN
   assign w_up_clr = w_kchg | w_dn_term;
   assign w_dn_clr = w_kchg | w_up_term;
`else
   assign w_up_clr = w_kchg;
   assign w_dn_clr = w_kchg;
`endif

   assign w_ltmr_nxt = w_pulse ? '0 : (&r_ltmr) ? r_ltmr : r_ltmr + 1'b1;

   mod_k_cnt #(.W(CNT_W)) u_up (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_en    (w_up_en),
      .i_clr   (w_up_clr),
      .i_max   (w_max),
      .o_term  (w_up_term),
      .o_pulse (carry)
   );

   mod_k_cnt #(.W(CNT_W)) u_dn (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_en    (w_dn_en),
      .i_clr   (w_dn_clr),
      .i_max   (w_max),
      .o_term  (w_dn_term),
      .o_pulse (borrow)
   );

   // Track kmode and run the saturating quiet-cycle timer that drives lock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_kmode <= '0;
         r_ltmr  <= '0;
         lock    <= 1'b0;
      end else begin
         r_kmode <= kmode;
         if (w_kchg) begin
            r_ltmr <= '0;
            lock   <= 1'b0;
         end else if (enable) begin
            r_ltmr <= w_ltmr_nxt;
            lock   <= &w_ltmr_nxt;
         end
      end
   end

endmodule
